// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared SVM pipeline types, widths and saturation helper
package svm_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;
    localparam logic [DATA_WIDTH-1:0] ACCUM_INIT = '0;

    localparam longint DATA_MAX = (longint'(1) <<< (DATA_WIDTH - 1)) - 1;
    localparam longint DATA_MIN = -(longint'(1) <<< (DATA_WIDTH - 1));

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } mac_state_e;

    // Callers sign-extend their (already shifted) value to 64 bits first.
    function automatic logic [DATA_WIDTH-1:0] sat_to_data(input longint v);
        if (v > DATA_MAX) begin
            return DATA_WIDTH'(DATA_MAX);
        end else if (v < DATA_MIN) begin
            return DATA_WIDTH'(DATA_MIN);
        end
        return DATA_WIDTH'(v);
    endfunction

endpackage

// File: rtl/svm_mac_stage_if.sv
// rtl/svm_mac_stage_if.sv - beat stream in, result pulse out of the MAC stage
interface svm_mac_stage_if #(
    parameter int DATA_WIDTH = svm_pkg::DATA_WIDTH
);
    logic                  in_vld;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] feat_in;
    logic [DATA_WIDTH-1:0] wt_in;
    logic [DATA_WIDTH-1:0] bias_in;
    logic                  in_last;
    logic [DATA_WIDTH-1:0] mac_data_out;
    logic                  stg_en;
    logic                  err_len;

    modport master (
        output in_vld, feat_in, wt_in, bias_in, in_last,
        input  in_rdy, mac_data_out, stg_en, err_len
    );

    modport slave (
        input  in_vld, feat_in, wt_in, bias_in, in_last,
        output in_rdy, mac_data_out, stg_en, err_len
    );
endinterface

// File: rtl/svm_mac_sat.sv
// rtl/svm_mac_sat.sv - Q-format shift and saturate from accumulator width to data width
module svm_mac_sat #(
    parameter int ACC_W     = 41,
    parameter int FRAC_BITS = svm_pkg::FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]              acc,
    output logic        [svm_pkg::DATA_WIDTH-1:0] data
);
    import svm_pkg::*;

    logic signed [ACC_W-1:0] shifted;

    // Arithmetic shift floors toward -inf; ACC_W must not exceed 64.
    assign shifted = acc >>> FRAC_BITS;
    assign data    = sat_to_data(longint'(shifted));

endmodule

// File: rtl/svm_mac_stage.sv
// rtl/svm_mac_stage.sv - bias plus feature-weight dot product with saturated pulse output
module svm_mac_stage #(
    parameter int FRAC_BITS    = svm_pkg::FRAC_BITS,
    parameter int NUM_FEATURES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    svm_mac_stage_if.slave   mac
);
    import svm_pkg::*;

    localparam int CNT_W = $clog2(NUM_FEATURES);
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(NUM_FEATURES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_FEATURES - 1);

    mac_state_e                  state, state_nxt;
    logic signed [ACC_W-1:0]     acc, acc_nxt;
    logic        [CNT_W-1:0]     cnt, cnt_nxt;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]     bias_ext;
    logic signed [ACC_W-1:0]     base;
    logic signed [ACC_W-1:0]     sum;
    logic                        accept;
    logic                        at_last_cnt;
    logic                        terminate;
    logic                        len_err;
    logic        [DATA_WIDTH-1:0] sat_data;
    logic        [DATA_WIDTH-1:0] data_q;
    logic                        stg_q;
    logic                        err_q;

    assign mac.in_rdy = !clear;
    assign accept     = mac.in_vld && mac.in_rdy;

    assign prod     = $signed(mac.feat_in) * $signed(mac.wt_in);
    assign bias_ext = ACC_W'($signed(mac.bias_in));
    // The first beat of a vector starts from the bias lifted into product scale.
    assign base     = (state == IDLE) ? (bias_ext <<< FRAC_BITS) : acc;
    assign sum      = base + ACC_W'(prod);

    assign at_last_cnt = (cnt == LAST_CNT);
    assign terminate   = accept && (mac.in_last || at_last_cnt);
    assign len_err     = terminate && !(mac.in_last && at_last_cnt);

    svm_mac_sat #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat (
        .acc  (sum),
        .data (sat_data)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        if (clear) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end else if (accept) begin
            if (terminate) begin
                state_nxt = IDLE;
                acc_nxt   = '0;
                cnt_nxt   = '0;
            end else begin
                state_nxt = ACCUM;
                acc_nxt   = sum;
                cnt_nxt   = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            data_q <= ACCUM_INIT;
            stg_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            stg_q <= terminate;
            err_q <= len_err;
            if (terminate) begin
                data_q <= sat_data;
            end
        end
    end

    assign mac.mac_data_out = data_q;
    assign mac.stg_en       = stg_q;
    assign mac.err_len      = err_q;

endmodule

// File: tb/tb_svm_mac_stage.sv
// tb/tb_svm_mac_stage.sv - directed self-checking bench for svm_mac_stage
module tb_svm_mac_stage;

    localparam int NF   = 8;
    localparam int FRAC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    svm_mac_stage_if #(.DATA_WIDTH(16)) bus ();

    svm_mac_stage #(
        .FRAC_BITS    (FRAC),
        .NUM_FEATURES (NF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .mac   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        e;
        int          c;
    } pulse_t;
    pulse_t pq[$];

    // Model state: running real-valued sum of the vector in product scale.
    longint      m_sum   = 0;
    int          m_beats = 0;
    logic        exp_stg = 1'b0;
    logic        exp_err = 1'b0;
    logic [15:0] exp_data = 16'h0000;

    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum    = 0;
            m_beats  = 0;
            exp_stg  = 1'b0;
            exp_err  = 1'b0;
            exp_data = 16'h0000;
        end else begin
            cyc++;
            exp_stg = 1'b0;
            exp_err = 1'b0;
            if (clear) begin
                m_sum   = 0;
                m_beats = 0;
            end else if (bus.in_vld) begin
                if (m_beats == 0) m_sum = longint'($signed(bus.bias_in)) * (longint'(1) << FRAC);
                m_sum += longint'($signed(bus.feat_in)) * longint'($signed(bus.wt_in));
                m_beats++;
                if (bus.in_last || m_beats == NF) begin
                    exp_stg  = 1'b1;
                    exp_err  = !(bus.in_last && m_beats == NF);
                    exp_data = sat16(m_sum >>> FRAC);
                    m_beats  = 0;
                    m_sum    = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("stg_en", {31'd0, bus.stg_en}, {31'd0, exp_stg});
        check("err_len", {31'd0, bus.err_len}, {31'd0, exp_err});
        check("mac_data_out", {16'd0, bus.mac_data_out}, {16'd0, exp_data});
        if (bus.stg_en === 1'b1) pq.push_back('{bus.mac_data_out, bus.err_len, cyc});
    end

    task automatic drive(input logic v, input logic [15:0] f, input logic [15:0] w,
                         input logic [15:0] b, input logic l, input logic c);
        bus.in_vld  = v;
        bus.feat_in = f;
        bus.wt_in   = w;
        bus.bias_in = b;
        bus.in_last = l;
        clear       = c;
        @(posedge clk);
        #1;
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic vec(input int n, input logic [15:0] f, input logic [15:0] w,
                       input logic [15:0] b, input int last_on);
        for (int i = 1; i <= n; i++) drive(1'b1, f, w, b, i == last_on, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_pulses(input string name, input int n,
                                input logic [15:0] d0, input logic e0,
                                input logic [15:0] d1, input logic e1);
        check({name, " count"}, pq.size(), n);
        if (n >= 1 && pq.size() >= 1) begin
            check({name, " data0"}, {16'd0, pq[0].d}, {16'd0, d0});
            check({name, " err0"}, {31'd0, pq[0].e}, {31'd0, e0});
        end
        if (n >= 2 && pq.size() >= 2) begin
            check({name, " data1"}, {16'd0, pq[1].d}, {16'd0, d1});
            check({name, " err1"}, {31'd0, pq[1].e}, {31'd0, e1});
        end
        pq.delete();
    endtask

    initial begin
        bus.in_vld  = 1'b0;
        bus.feat_in = '0;
        bus.wt_in   = '0;
        bus.bias_in = '0;
        bus.in_last = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset data", {16'd0, bus.mac_data_out}, 32'h0);
        check("reset stg_en", {31'd0, bus.stg_en}, 32'h0);
        check("reset err_len", {31'd0, bus.err_len}, 32'h0);
        check("reset in_rdy", {31'd0, bus.in_rdy}, 32'h1);
        rst_n = 1'b1;
        idle(1);

        vec(8, 16'h0100, 16'h0100, 16'h0000, 8);
        idle(2);
        check_pulses("unit8", 1, 16'h0800, 1'b0, 16'h0, 1'b0);

        vec(8, 16'h7F00, 16'h7F00, 16'h0000, 8);
        vec(8, 16'h7F00, 16'h8100, 16'h0000, 8);
        idle(2);
        check_pulses("sat", 2, 16'h7FFF, 1'b0, 16'h8000, 1'b0);

        vec(8, 16'h0100, 16'h0100, 16'h0200, 8);
        vec(8, 16'h0100, 16'h0100, 16'hFE00, 8);
        idle(2);
        if (pq.size() == 2) check("b2b spacing", pq[1].c - pq[0].c, 8);
        else check("b2b spacing pulses", pq.size(), 2);
        check_pulses("b2b", 2, 16'h0A00, 1'b0, 16'h0600, 1'b0);

        vec(3, 16'h0100, 16'h0100, 16'h0000, 3);
        vec(8, 16'h0100, 16'h0100, 16'h0000, 8);
        idle(2);
        check_pulses("short", 2, 16'h0300, 1'b1, 16'h0800, 1'b0);

        vec(8, 16'h0100, 16'h0100, 16'h0000, 0);
        vec(2, 16'h0001, 16'hFFFF, 16'h0000, 2);
        idle(2);
        check_pulses("nolast_floor", 2, 16'h0800, 1'b1, 16'hFFFF, 1'b1);

        vec(4, 16'h0100, 16'h0100, 16'h0000, 0);
        bus.in_vld = 1'b1;
        clear = 1'b1;
        #1;
        check("clear in_rdy", {31'd0, bus.in_rdy}, 32'h0);
        drive(1'b1, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1);
        idle(3);
        check_pulses("clear none", 0, 16'h0, 1'b0, 16'h0, 1'b0);
        vec(8, 16'h0100, 16'h0100, 16'h0000, 8);
        idle(2);
        check_pulses("after clear", 1, 16'h0800, 1'b0, 16'h0, 1'b0);

        vec(3, 16'h0100, 16'h0100, 16'h0300, 0);
        idle(2);
        vec(2, 16'h0100, 16'h0100, 16'h0300, 0);
        bus.in_vld  = 1'b1;
        bus.feat_in = 16'h0100;
        bus.wt_in   = 16'h0100;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst data", {16'd0, bus.mac_data_out}, 32'h0);
        check("async rst stg_en", {31'd0, bus.stg_en}, 32'h0);
        bus.in_vld = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        vec(8, 16'h0100, 16'h0100, 16'h0000, 8);
        idle(2);
        check_pulses("post reset", 1, 16'h0800, 1'b0, 16'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
